// File: rtl/gpu_rect_fill.sv
// gpu_rect_fill: fills an axis-aligned rectangle in a grey-level frame buffer.
// Each pixel is visited in raster order. An on-screen pixel takes a read phase
// of RD_LAT cycles followed by a one-cycle write. An off-screen pixel takes a
// single skip cycle and issues no access. A one-cycle done pulse ends the command.
//
// Ports:
//   Clk, Reset            sole clock; synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_x0/y0/w/h/color   rectangle origin, size (0 = empty) and grey level
//   gpu_access            frame-buffer port request (read and write phases)
//   gpu_x/gpu_y           current pixel coordinate
//   gpu_data/gpu_we       write value and one-cycle write strobe
//   busy/done             command in progress / completion pulse
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// READ   | RD_LAT cycles presenting the cursor for a read
// WRITE  | one-cycle write of the latched colour at the cursor
// SKIP   | one cycle for an off-screen pixel, no access
// DONE   | one-cycle completion pulse
module gpu_rect_fill #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int RD_LAT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_x0,
  input  logic [9:0] cmd_y0,
  input  logic [9:0] cmd_w,
  input  logic [9:0] cmd_h,
  input  logic [3:0] cmd_color,
  output logic       gpu_access,
  output logic [9:0] gpu_x,
  output logic [9:0] gpu_y,
  output logic [3:0] gpu_data,
  output logic       gpu_we,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_SKIP, S_DONE} state_t;

  localparam logic [2:0]  RD_LOAD = 3'(RD_LAT - 1);
  localparam logic [10:0] H_LIM   = 11'(H_RES);
  localparam logic [10:0] V_LIM   = 11'(V_RES);

  // Cursor and end coordinates are 11 bits so a rectangle running past 1023
  // stays off-screen instead of wrapping back to low columns/rows.
  function automatic logic in_bounds(input logic [10:0] x, input logic [10:0] y);
    return (x < H_LIM) && (y < V_LIM);
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [10:0] cx_q, cx_d, cy_q, cy_d;
  logic [10:0] x0_q, x0_d, x_end_q, x_end_d, y_end_q, y_end_d;
  logic [3:0]  color_q, color_d;

  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        gpu_access_q, gpu_access_d;
  logic        gpu_we_q, gpu_we_d;
  logic [9:0]  gpu_x_q, gpu_x_d, gpu_y_q, gpu_y_d;
  logic [3:0]  gpu_data_q, gpu_data_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    x0_d    = x0_q;
    x_end_d = x_end_q;
    y_end_d = y_end_q;
    color_d = color_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          x0_d    = {1'b0, cmd_x0};
          cx_d    = {1'b0, cmd_x0};
          cy_d    = {1'b0, cmd_y0};
          x_end_d = {1'b0, cmd_x0} + {1'b0, cmd_w} - 11'd1;
          y_end_d = {1'b0, cmd_y0} + {1'b0, cmd_h} - 11'd1;
          color_d = cmd_color;
          cnt_d   = RD_LOAD;
          if (cmd_w == 10'd0 || cmd_h == 10'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = in_bounds(cx_d, cy_d) ? S_READ : S_SKIP;
          end
        end
      end
      S_READ: begin
        if (cnt_q == 3'd0) begin
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_WRITE, S_SKIP: begin
        if (cx_q == x_end_q && cy_q == y_end_q) begin
          state_d = S_DONE;
        end else begin
          if (cx_q == x_end_q) begin
            cx_d = x0_q;
            cy_d = cy_q + 11'd1;
          end else begin
            cx_d = cx_q + 11'd1;
          end
          cnt_d   = RD_LOAD;
          state_d = in_bounds(cx_d, cy_d) ? S_READ : S_SKIP;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state and registered alongside it.
    cmd_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    gpu_access_d = (state_d == S_READ) || (state_d == S_WRITE);
    gpu_we_d     = (state_d == S_WRITE);
    gpu_x_d      = cx_d[9:0];
    gpu_y_d      = cy_d[9:0];
    gpu_data_d   = color_d;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 3'd0;
      cx_q         <= 11'd0;
      cy_q         <= 11'd0;
      x0_q         <= 11'd0;
      x_end_q      <= 11'd0;
      y_end_q      <= 11'd0;
      color_q      <= 4'd0;
      cmd_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      gpu_access_q <= 1'b0;
      gpu_we_q     <= 1'b0;
      gpu_x_q      <= 10'd0;
      gpu_y_q      <= 10'd0;
      gpu_data_q   <= 4'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      x0_q         <= x0_d;
      x_end_q      <= x_end_d;
      y_end_q      <= y_end_d;
      color_q      <= color_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      gpu_access_q <= gpu_access_d;
      gpu_we_q     <= gpu_we_d;
      gpu_x_q      <= gpu_x_d;
      gpu_y_q      <= gpu_y_d;
      gpu_data_q   <= gpu_data_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign gpu_access = gpu_access_q;
  assign gpu_we     = gpu_we_q;
  assign gpu_x      = gpu_x_q;
  assign gpu_y      = gpu_y_q;
  assign gpu_data   = gpu_data_q;

endmodule

// File: tb/tb_gpu_rect_fill.sv
// tb_gpu_rect_fill: directed bench for gpu_rect_fill. A pixel-level model
// expands each command into the expected per-cycle output trace; a compare
// process checks every cycle against it. Literal cycle/write counts and write
// orders pin both the model and the DUT.
module tb_gpu_rect_fill;
  localparam int H  = 640;
  localparam int V  = 480;
  localparam int RL = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [9:0] cmd_x0 = '0, cmd_y0 = '0, cmd_w = '0, cmd_h = '0;
  logic [3:0] cmd_color = '0;
  logic       cmd_ready, gpu_access, gpu_we, busy, done;
  logic [9:0] gpu_x, gpu_y;
  logic [3:0] gpu_data;

  gpu_rect_fill #(.H_RES(H), .V_RES(V), .RD_LAT(RL)) dut (
    .Clk(clk), .Reset(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .gpu_access(gpu_access), .gpu_x(gpu_x),
    .gpu_y(gpu_y), .gpu_data(gpu_data), .gpu_we(gpu_we), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         busy, done, acc, we, ready;
    logic [9:0] x, y;
    logic [3:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          chk_idle = 1'b0;
  int          wr_cnt = 0;
  logic [19:0] wr_log[$];

  task automatic check(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic push_cyc(input bit b, input bit d, input bit a, input bit w,
                          input bit r, input int x, input int y, input int c);
    exp_t e;
    e.busy = b; e.done = d; e.acc = a; e.we = w; e.ready = r;
    e.x = 10'(x); e.y = 10'(y); e.data = 4'(c);
    exp_q.push_back(e);
  endtask

  // Expected trace of one command, starting with the cycle after acceptance.
  task automatic model_cmd(input int x0, input int y0, input int w, input int h,
                           input int c, output int n);
    n = 0;
    if (w != 0 && h != 0) begin
      for (int yy = y0; yy < y0 + h; yy++) begin
        for (int xx = x0; xx < x0 + w; xx++) begin
          if (xx < H && yy < V) begin
            for (int k = 0; k < RL; k++) push_cyc(1, 0, 1, 0, 0, xx, yy, c);
            push_cyc(1, 0, 1, 1, 0, xx, yy, c);
            n += RL + 1;
          end else begin
            push_cyc(1, 0, 0, 0, 0, 0, 0, 0);
            n++;
          end
        end
      end
    end
    push_cyc(1, 1, 0, 0, 0, 0, 0, 0);
    n++;
  endtask

  always @(negedge clk) begin
    if (gpu_we) begin
      wr_cnt++;
      wr_log.push_back({gpu_x, gpu_y});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    bit ok;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      ok = (busy == e.busy) && (done == e.done) && (gpu_access == e.acc) &&
           (gpu_we == e.we) && (cmd_ready == e.ready);
      if (e.acc && (gpu_x != e.x || gpu_y != e.y)) ok = 1'b0;
      if (e.we && gpu_data != e.data) ok = 1'b0;
      n_vec++;
      if (!ok) begin
        n_err++;
        $display("FAIL trace @%0t: got busy=%0b done=%0b acc=%0b we=%0b rdy=%0b x=%0d y=%0d d=%0h, expected busy=%0b done=%0b acc=%0b we=%0b rdy=%0b x=%0d y=%0d d=%0h",
                 $time, busy, done, gpu_access, gpu_we, cmd_ready, gpu_x, gpu_y, gpu_data,
                 e.busy, e.done, e.acc, e.we, e.ready, e.x, e.y, e.data);
      end
    end else if (chk_idle) begin
      n_vec++;
      if (busy || done || gpu_access || gpu_we || !cmd_ready) begin
        n_err++;
        $display("FAIL idle @%0t: got busy=%0b done=%0b acc=%0b we=%0b rdy=%0b, expected 0 0 0 0 1",
                 $time, busy, done, gpu_access, gpu_we, cmd_ready);
      end
    end
  end

  // Called at posedge+1 with the DUT idle.
  task automatic run(input int x0, input int y0, input int w, input int h, input int c,
                     input int lit_cyc, input int lit_wr, input string name);
    int n, k, w0;
    cmd_x0 = 10'(x0); cmd_y0 = 10'(y0); cmd_w = 10'(w); cmd_h = 10'(h); cmd_color = 4'(c);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    model_cmd(x0, y0, w, h, c, n);
    check({name, " model_cycles"}, n, lit_cyc);
    w0 = wr_cnt;
    k = 1;
    while (!done && k < 4000) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, " cycles_to_done"}, k, lit_cyc);
    if (!done) exp_q.delete();
    @(posedge clk); #1;
    check({name, " writes"}, wr_cnt - w0, lit_wr);
    check({name, " ready_after"}, int'(cmd_ready), 1);
  endtask

  task automatic check_order(input string name, input logic [19:0] want[$]);
    check({name, " order_len"}, wr_log.size(), want.size());
    for (int i = 0; i < want.size() && i < wr_log.size(); i++)
      check({name, " order"}, int'(wr_log[i]), int'(want[i]));
  endtask

  initial begin
    int nA, nB, w0, nw, k;
    logic [19:0] ord[$];

    repeat (2) @(posedge clk);
    #1;
    check("rst cmd_ready", int'(cmd_ready), 1);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst gpu_access", int'(gpu_access), 0);
    check("rst gpu_we", int'(gpu_we), 0);
    check("rst gpu_x", int'(gpu_x), 0);
    check("rst gpu_y", int'(gpu_y), 0);
    check("rst gpu_data", int'(gpu_data), 0);
    rst = 1'b0;
    chk_idle = 1'b1;
    @(posedge clk); #1;

    wr_log.delete();
    run(10, 20, 2, 1, 'hA, 7, 2, "two_px");
    ord = '{{10'd10, 10'd20}, {10'd11, 10'd20}};
    check_order("two_px", ord);

    wr_log.delete();
    run(0, 0, 3, 2, 5, 19, 6, "3x2");
    ord = '{{10'd0, 10'd0}, {10'd1, 10'd0}, {10'd2, 10'd0},
            {10'd0, 10'd1}, {10'd1, 10'd1}, {10'd2, 10'd1}};
    check_order("3x2", ord);

    wr_log.delete();
    run(638, 479, 4, 2, 'hC, 13, 2, "corner_clip");
    ord = '{{10'd638, 10'd479}, {10'd639, 10'd479}};
    check_order("corner_clip", ord);

    run(7, 7, 0, 5, 1, 1, 0, "w0");
    run(3, 3, 4, 0, 1, 1, 0, "h0");
    run(1020, 0, 10, 1, 2, 11, 0, "x_wrap");
    run(0, 478, 2, 3, 9, 15, 4, "bottom_clip");
    run(700, 10, 2, 2, 4, 5, 0, "offscreen");

    // Second command held valid through a 4x4 fill.
    cmd_x0 = 10'd100; cmd_y0 = 10'd100; cmd_w = 10'd4; cmd_h = 10'd4; cmd_color = 4'd7;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    model_cmd(100, 100, 4, 4, 7, nA);
    check("held model_A", nA, 49);
    push_cyc(0, 0, 0, 0, 1, 0, 0, 0);
    cmd_x0 = 10'd5; cmd_y0 = 10'd5; cmd_w = 10'd1; cmd_h = 10'd2; cmd_color = 4'd3;
    model_cmd(5, 5, 1, 2, 3, nB);
    check("held model_B", nB, 7);
    w0 = wr_cnt;
    repeat (48) begin @(posedge clk); #1; end
    check("held done_A", int'(done), 1);
    check("held writes_A", wr_cnt - w0, 16);
    @(posedge clk); #1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    w0 = wr_cnt;
    repeat (6) begin @(posedge clk); #1; end
    check("held done_B", int'(done), 1);
    @(posedge clk); #1;
    check("held writes_B", wr_cnt - w0, 2);

    // Reset during the write of pixel 3 of a 4x2 fill.
    cmd_x0 = 10'd0; cmd_y0 = 10'd0; cmd_w = 10'd4; cmd_h = 10'd2; cmd_color = 4'hB;
    cmd_valid = 1'b1;
    w0 = wr_cnt;
    @(posedge clk); #1;
    chk_idle = 1'b0;
    cmd_valid = 1'b0;
    nw = 0; k = 0;
    while (k < 200) begin
      if (gpu_we) nw++;
      if (nw == 3) break;
      @(posedge clk); #1;
      k++;
    end
    check("rst_mid reached_write3", nw, 3);
    check("rst_mid px3_x", int'(gpu_x), 2);
    rst = 1'b1;
    cmd_x0 = 10'd50; cmd_y0 = 10'd50; cmd_w = 10'd1; cmd_h = 10'd1;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    check("rst_mid gpu_we", int'(gpu_we), 0);
    check("rst_mid busy", int'(busy), 0);
    check("rst_mid ready", int'(cmd_ready), 1);
    @(posedge clk); #1;
    check("rst_hold no_accept", int'(busy), 0);
    cmd_valid = 1'b0;
    rst = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("rst_mid total_writes", wr_cnt - w0, 3);
    chk_idle = 1'b1;

    wr_log.delete();
    run(1, 1, 1, 1, 6, 4, 1, "after_rst");
    ord = '{{10'd1, 10'd1}};
    check_order("after_rst", ord);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gpu_rect_fill.md
GPU_RECT_FILL -- requirements
Module: gpu_rect_fill

Interface
REQ-001 Parameter H_RES, default 640, visible columns; x >= H_RES is off-screen.
REQ-002 Parameter V_RES, default 480, visible rows; y >= V_RES is off-screen.
REQ-003 Parameter RD_LAT, default 2, cycles from address presentation to valid merged read data in the frame buffer; range 1..7.
REQ-004 Clk  input  1  sole clock, same domain as the frame buffer write clock; one clock; reset is synchronous and active-high.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 cmd_valid  input  1  command present.
REQ-007 cmd_ready  output  1  block can accept a command.
REQ-008 cmd_x0, cmd_y0  input  10 each  top-left corner.
REQ-009 cmd_w, cmd_h  input  10 each  width/height in pixels; 0 = empty rectangle.
REQ-010 cmd_color  input  4  grey level to write.
REQ-011 gpu_access  output  1  requests frame-buffer read port for the GPU side.
REQ-012 gpu_x, gpu_y  output  10 each  current pixel coordinate.
REQ-013 gpu_data  output  4  pixel value to write.
REQ-014 gpu_we  output  1  one-cycle write strobe.
REQ-015 busy  output  1  command in progress.
REQ-016 done  output  1  one-cycle pulse at command completion.

Function
REQ-017 States IDLE, READ, WRITE, SKIP, DONE, encoded one state register.
REQ-018 cmd_ready SHALL be 1 only in IDLE; handshake = cmd_valid && cmd_ready at rising Clk; command fields latched at that edge; inputs ignored otherwise.
REQ-019 On accept: cursor = (cmd_x0, cmd_y0); if cmd_w == 0 or cmd_h == 0 -> DONE; else -> READ if cursor in bounds, SKIP if not.
REQ-020 In bounds: cursor_x < H_RES and cursor_y < V_RES, compared at 11 bits so x0+w-1 > 1023 never wraps into range.
REQ-021 READ SHALL last exactly RD_LAT cycles (internal 3-bit counter), gpu_access = 1, gpu_x/gpu_y = cursor, gpu_we = 0, then -> WRITE.
REQ-022 WRITE SHALL last 1 cycle: gpu_access = 1, gpu_we = 1, gpu_x/gpu_y unchanged from READ, gpu_data = latched color.
REQ-023 SKIP SHALL last 1 cycle with gpu_access = 0, gpu_we = 0; no read or write issued for off-screen pixels.
REQ-024 After WRITE or SKIP the cursor advances raster order: x+1; when x == x0+w-1, x = x0 and y+1; if the pixel was (x0+w-1, y0+h-1) -> DONE, else -> READ/SKIP per REQ-020 for the new cursor.
REQ-025 DONE SHALL last 1 cycle with done = 1, then -> IDLE.
REQ-026 busy = 1 in READ, WRITE, SKIP, DONE; 0 in IDLE.
REQ-027 gpu_access and gpu_we SHALL be 0 in IDLE, SKIP, DONE; gpu_we never asserted twice for the same pixel.
REQ-028 Per in-bounds pixel cost: RD_LAT+1 cycles; per clipped pixel: 1 cycle; command overhead: 1 DONE cycle.
REQ-029 cmd_valid during busy SHALL be ignored with no effect on the running fill.
REQ-030 All outputs registered-state derived; no combinational path from cmd_* inputs to gpu_* outputs.

Reset
REQ-031 Reset SHALL, at the next rising Clk, force IDLE, cmd_ready = 1, busy = 0, done = 0, gpu_access = 0, gpu_we = 0, gpu_x = 0, gpu_y = 0, gpu_data = 0, counters cleared.
REQ-032 Reset mid-operation SHALL abandon the fill with no further gpu_we pulses; pixels already written stay written.
REQ-033 A command presented while Reset is high SHALL NOT be accepted.

Verification
REQ-034 x0=10,y0=20,w=2,h=1,color=0xA, RD_LAT=2 -> READ(10,20) 2 cycles, WRITE(10,20), READ(11,20) 2 cycles, WRITE(11,20), done pulse 7 cycles after accept, exactly 2 gpu_we pulses with gpu_data=0xA.
REQ-035 w=3,h=2 at (0,0) -> write order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); 6 gpu_we pulses.
REQ-036 x0=638,y0=479,w=4,h=2 -> writes only (638,479),(639,479); 6 clipped pixels take 1 cycle each with gpu_access=0; total 2*3+6+1 = 13 cycles to done.
REQ-037 w=0,h=5 -> no gpu_we, done one cycle after accept, cmd_ready back next cycle.
REQ-038 Second cmd_valid held during a 4x4 fill -> ignored, accepted only after DONE; reference model pixel count 16 then second command's count.
REQ-039 Reset asserted in WRITE of pixel 3 of 8 -> gpu_we=0 and busy=0 next edge, no further writes, new command accepted afterwards.
